// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: load/start/pause inputs plus
// the registered count and state flags.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             go;
    logic             hold;
    logic [WIDTH-1:0] Q;
    logic             running;
    logic             done;
    logic             expired;

    modport master (
        output load, load_value, go, hold,
        input  Q, running, done, expired
    );

    modport slave (
        input  load, load_value, go, hold,
        output Q, running, done, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter stepping once every TICK_DIV cycles while running,
// with start/pause/abort control and a sticky expiry flag.
module countdown_timer #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             clear_b,
    countdown_timer_if.slave tif
);
    localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [WIDTH-1:0] Q_ZERO   = WIDTH'(0);
    localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic             running_r;
    logic             done_r;
    logic             expired_r;

    // State, count, divider and flag registers; flags are derived from the next state
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            state_r   <= ST_IDLE;
            q_r       <= Q_ZERO;
            div_r     <= DIV_ZERO;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            q_r       <= q_nxt_s;
            div_r     <= div_nxt_s;
            running_r <= (state_nxt_s == ST_RUN);
            done_r    <= (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
            expired_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Next-state logic; load overrides everything, hold beats go inside RUN/PAUSED
    always_comb begin
        state_nxt_s = state_r;
        q_nxt_s     = q_r;
        div_nxt_s   = div_r;
        if (tif.load) begin
            state_nxt_s = ST_IDLE;
            q_nxt_s     = tif.load_value;
            div_nxt_s   = DIV_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tif.go && (q_r != Q_ZERO)) begin
                        state_nxt_s = ST_RUN;
                        div_nxt_s   = DIV_ZERO;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A hold edge freezes the divider even at terminal count
                    if (tif.hold) begin
                        state_nxt_s = ST_PAUSED;
                    end else if (div_r == DIV_LAST) begin
                        q_nxt_s   = q_r - Q_ONE;
                        div_nxt_s = DIV_ZERO;
                        if (q_r == Q_ONE) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        div_nxt_s = div_r + DIV_ONE;
                    end
                end
                ST_PAUSED: begin
                    if (tif.go && !tif.hold) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_PAUSED;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                    q_nxt_s     = Q_ZERO;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    q_nxt_s     = Q_ZERO;
                    div_nxt_s   = DIV_ZERO;
                end
            endcase
        end
    end

    assign tif.Q       = q_r;
    assign tif.running = running_r;
    assign tif.done    = done_r;
    assign tif.expired = expired_r;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// control traffic, all compared against an elapsed-cycle arithmetic model.
module tb_countdown_timer;
    localparam int W = 8;
    localparam int T = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk     = 1'b0;
    logic clear_b = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    // Model: count = loaded - (effective run cycles / T)
    int   m_mode = M_IDLE;
    int   m_n    = 0;
    int   m_rc   = 0;
    bit   m_done = 1'b0;

    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(W)) ifa ();
    countdown_timer_if #(.WIDTH(W)) ifb ();

    countdown_timer #(.WIDTH(W), .TICK_DIV(T)) dut_a (
        .clk(clk), .clear_b(clear_b), .tif(ifa.slave)
    );
    countdown_timer #(.WIDTH(W), .TICK_DIV(1)) dut_b (
        .clk(clk), .clear_b(clear_b), .tif(ifb.slave)
    );

    function automatic logic [W+2:0] exp_vec();
        logic [W-1:0] q;
        q = W'(m_n - m_rc / T);
        return {q, m_mode == M_RUN, m_done, m_mode == M_DONE};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_n    = 0;
        m_rc   = 0;
        m_done = 1'b0;
    endtask

    // One clock edge of dut_a with the model advanced on the same sampled inputs
    task automatic step_a();
        @(posedge clk);
        m_done = 1'b0;
        if (ifa.load) begin
            m_n    = int'(ifa.load_value);
            m_rc   = 0;
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE:  if (ifa.go && m_n != 0) m_mode = M_RUN;
                M_RUN: begin
                    if (ifa.hold) begin
                        m_mode = M_PAUSE;
                    end else begin
                        m_rc++;
                        if (m_rc == m_n * T) begin
                            m_mode = M_DONE;
                            m_done = 1'b1;
                        end
                    end
                end
                M_PAUSE: if (ifa.go && !ifa.hold) m_mode = M_RUN;
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic load_a(input logic [W-1:0] v);
        ifa.load = 1'b1;
        ifa.load_value = v;
        step_a();
        ifa.load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== 11'd0) begin
            errors++;
            $display("FAIL reset_a got=%h exp=%h", {ifa.Q, ifa.running, ifa.done, ifa.expired}, 11'd0);
        end
        checks++;
        if ({ifb.Q, ifb.running, ifb.done, ifb.expired} !== 11'd0) begin
            errors++;
            $display("FAIL reset_b got=%h exp=%h", {ifb.Q, ifb.running, ifb.done, ifb.expired}, 11'd0);
        end
        @(negedge clk);
        clear_b = 1'b1;
        model_reset();
        step_a();
        checks++;
        if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", {ifa.Q, ifa.running, ifa.done, ifa.expired}, exp_vec());
        end
    endtask

    task automatic test_basic();
        load_a(8'd3);
        ifa.go = 1'b1;
        step_a();
        ifa.go = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step_a();
            checks++;
            if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== exp_vec()) begin
                errors++;
                $display("FAIL basic_model k=%0d got=%h exp=%h", k, {ifa.Q, ifa.running, ifa.done, ifa.expired}, exp_vec());
            end
            if (k == 4 || k == 8 || k == 12 || k == 13) begin
                logic [W+2:0] want;
                want = (k == 4) ? {8'd2, 3'b100} : (k == 8) ? {8'd1, 3'b100} :
                       (k == 12) ? {8'd0, 3'b011} : {8'd0, 3'b001};
                checks++;
                if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== want) begin
                    errors++;
                    $display("FAIL basic_fixed k=%0d got=%h exp=%h", k, {ifa.Q, ifa.running, ifa.done, ifa.expired}, want);
                end
            end
        end
    endtask

    task automatic test_pause();
        int done_at;
        done_at = -1;
        load_a(8'd5);
        ifa.go = 1'b1;
        step_a();
        ifa.go = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            ifa.hold = (k == 7);
            ifa.go   = (k == 10);
            step_a();
            if (ifa.done === 1'b1 && done_at < 0) done_at = k;
            checks++;
            if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== exp_vec()) begin
                errors++;
                $display("FAIL pause_model k=%0d got=%h exp=%h", k, {ifa.Q, ifa.running, ifa.done, ifa.expired}, exp_vec());
            end
            if ((k >= 7 && k <= 11 && ifa.Q !== 8'd4) || (k == 12 && ifa.Q !== 8'd3)) begin
                errors++;
                $display("FAIL pause_q k=%0d got=%0d", k, ifa.Q);
            end
            if (k >= 7 && k <= 12) checks++;
        end
        ifa.go   = 1'b0;
        ifa.hold = 1'b0;
        checks++;
        if (done_at !== 24) begin
            errors++;
            $display("FAIL pause_latency got=%0d exp=%0d", done_at, 24);
        end
    endtask

    task automatic test_abort();
        load_a(8'h20);
        ifa.go = 1'b1;
        step_a();
        ifa.go = 1'b0;
        repeat (9) step_a();
        ifa.load = 1'b1;
        ifa.load_value = 8'h07;
        step_a();
        ifa.load = 1'b0;
        checks++;
        if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== {8'h07, 3'b000}) begin
            errors++;
            $display("FAIL abort got=%h exp=%h", {ifa.Q, ifa.running, ifa.done, ifa.expired}, {8'h07, 3'b000});
        end
        repeat (3) begin
            step_a();
            checks++;
            if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== exp_vec()) begin
                errors++;
                $display("FAIL abort_idle got=%h exp=%h", {ifa.Q, ifa.running, ifa.done, ifa.expired}, exp_vec());
            end
        end
    endtask

    task automatic test_ignored();
        load_a(8'd0);
        ifa.go = 1'b1;
        repeat (3) step_a();
        ifa.go = 1'b0;
        checks++;
        if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== 11'd0) begin
            errors++;
            $display("FAIL go_zero got=%h exp=%h", {ifa.Q, ifa.running, ifa.done, ifa.expired}, 11'd0);
        end
        load_a(8'd1);
        ifa.go = 1'b1;
        step_a();
        ifa.go = 1'b0;
        repeat (5) step_a();
        ifa.go = 1'b1;
        ifa.hold = 1'b1;
        repeat (3) step_a();
        ifa.hold = 1'b0;
        repeat (2) step_a();
        ifa.go = 1'b0;
        checks++;
        if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== {8'd0, 3'b001}) begin
            errors++;
            $display("FAIL go_in_done got=%h exp=%h", {ifa.Q, ifa.running, ifa.done, ifa.expired}, {8'd0, 3'b001});
        end
        ifa.load = 1'b1;
        ifa.load_value = 8'h10;
        ifa.go = 1'b1;
        step_a();
        ifa.load = 1'b0;
        ifa.go = 1'b0;
        step_a();
        checks++;
        if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== {8'h10, 3'b000}) begin
            errors++;
            $display("FAIL load_go got=%h exp=%h", {ifa.Q, ifa.running, ifa.done, ifa.expired}, {8'h10, 3'b000});
        end
    endtask

    task automatic test_async_reset();
        load_a(8'd9);
        ifa.go = 1'b1;
        step_a();
        ifa.go = 1'b0;
        repeat (6) step_a();
        @(negedge clk);
        clear_b = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== 11'd0) begin
            errors++;
            $display("FAIL async_clear got=%h exp=%h", {ifa.Q, ifa.running, ifa.done, ifa.expired}, 11'd0);
        end
        @(negedge clk);
        clear_b = 1'b1;
        repeat (3) begin
            step_a();
            checks++;
            if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== exp_vec()) begin
                errors++;
                $display("FAIL async_after got=%h exp=%h", {ifa.Q, ifa.running, ifa.done, ifa.expired}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            ifa.load       = ($urandom_range(0, 99) < 6);
            ifa.load_value = W'($urandom_range(0, 5));
            ifa.go         = ($urandom_range(0, 3) == 0);
            ifa.hold       = ($urandom_range(0, 7) == 0);
            step_a();
            checks++;
            if ({ifa.Q, ifa.running, ifa.done, ifa.expired} !== exp_vec()) begin
                errors++;
                $display("FAIL random c=%0d got=%h exp=%h", c, {ifa.Q, ifa.running, ifa.done, ifa.expired}, exp_vec());
            end
        end
        ifa.load = 1'b0;
        ifa.go   = 1'b0;
        ifa.hold = 1'b0;
    endtask

    task automatic test_full_range();
        ifb.load = 1'b1;
        ifb.load_value = 8'hFF;
        @(posedge clk); #1;
        ifb.load = 1'b0;
        ifb.go = 1'b1;
        @(posedge clk); #1;
        ifb.go = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            logic [W+2:0] want;
            @(posedge clk); #1;
            want = (k < 255) ? {W'(255 - k), 3'b100} : {8'd0, 1'b0, k == 255, 1'b1};
            checks++;
            if ({ifb.Q, ifb.running, ifb.done, ifb.expired} !== want) begin
                errors++;
                $display("FAIL full_range k=%0d got=%h exp=%h", k, {ifb.Q, ifb.running, ifb.done, ifb.expired}, want);
            end
        end
    endtask

    initial begin
        ifa.load = 1'b0; ifa.load_value = 8'd0; ifa.go = 1'b0; ifa.hold = 1'b0;
        ifb.load = 1'b0; ifb.load_value = 8'd0; ifb.go = 1'b0; ifb.hold = 1'b0;
        test_reset();
        test_basic();
        test_pause();
        test_abort();
        test_ignored();
        test_async_reset();
        test_random();
        test_full_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
